// File: rtl/cond_check_pkg.sv
// Shared types for the condition-check collector: FSM states and the
// two-bit four-state value encoding.
package cond_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   localparam logic [1:0] V0 = 2'b00;
   localparam logic [1:0] V1 = 2'b01;
   localparam logic [1:0] VX = 2'b10;
   localparam logic [1:0] VZ = 2'b11;

endpackage

// File: rtl/cond_z_to_x_norm.sv
// Combinational Z->X folding of an encoded four-state vector so that a
// high-impedance value compares equal to an unknown one.
module cond_z_to_x_norm
   import cond_check_pkg::*;
#(
   parameter int SIZE = 1
) (
   input  logic [2*SIZE-1:0] i_val,
   output logic [2*SIZE-1:0] o_val
);

   // Per-digit rewrite of Z into X; other digits pass unchanged.
   always_comb begin
      o_val = i_val;
      for (int i = 0; i < SIZE; i++) begin
         if (i_val[2*i +: 2] == VZ) begin
            o_val[2*i +: 2] = VX;
         end else begin
            o_val[2*i +: 2] = i_val[2*i +: 2];
         end
      end
   end

endmodule

// File: rtl/cond_check_collector.sv
// Collects expected/actual four-state vector pairs over a session, counts
// mismatches after one pipeline stage and presents a held summary report.
module cond_check_collector
   import cond_check_pkg::*;
#(
   parameter int SIZE  = 1,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                chk_valid,
   output logic                chk_ready,
   input  logic                chk_last,
   input  logic [2*SIZE-1:0]   exp_val,
   input  logic [2*SIZE-1:0]   act_val,
   output logic                report_valid,
   input  logic                report_ready,
   output logic                pass,
   output logic [CNT_W-1:0]    vec_count,
   output logic [CNT_W-1:0]    err_count,
   output logic [CNT_W-1:0]    first_err_idx,
   output logic [2*SIZE-1:0]   first_err_exp,
   output logic [2*SIZE-1:0]   first_err_act
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [2*SIZE-1:0] VEC_ZERO = {(2*SIZE){1'b0}};

   state_t              r_state;
   logic                r_chk_ready;
   logic                r_report_valid;
   logic                r_pass;
   logic                r_p_valid;
   logic                r_p_mis;
   logic [2*SIZE-1:0]   r_p_exp;
   logic [2*SIZE-1:0]   r_p_act;
   logic [CNT_W-1:0]    r_vec_count;
   logic [CNT_W-1:0]    r_err_count;
   logic [CNT_W-1:0]    r_first_idx;
   logic [2*SIZE-1:0]   r_first_exp;
   logic [2*SIZE-1:0]   r_first_act;

   logic [2*SIZE-1:0]   w_exp_n;
   logic [2*SIZE-1:0]   w_act_n;
   logic                w_mis;
   logic                w_accept;
   logic                w_p_err;
   logic [CNT_W-1:0]    w_vec_next;
   logic [CNT_W-1:0]    w_err_next;

   cond_z_to_x_norm #(.SIZE(SIZE)) u_norm_exp (.i_val(exp_val), .o_val(w_exp_n));
   cond_z_to_x_norm #(.SIZE(SIZE)) u_norm_act (.i_val(act_val), .o_val(w_act_n));

   // A pair offered together with start belongs to neither session.
   assign w_accept = chk_valid && r_chk_ready && !start;
   assign w_mis    = (w_exp_n != w_act_n);
   assign w_p_err  = r_p_valid && r_p_mis;

   // Saturating next-count values for the retiring pipeline entry.
   always_comb begin
      w_vec_next = r_vec_count;
      w_err_next = r_err_count;
      if (r_p_valid && (r_vec_count != CNT_MAX)) begin
         w_vec_next = r_vec_count + CNT_ONE;
      end else begin
         w_vec_next = r_vec_count;
      end
      if (w_p_err && (r_err_count != CNT_MAX)) begin
         w_err_next = r_err_count + CNT_ONE;
      end else begin
         w_err_next = r_err_count;
      end
   end

   // Session FSM with its registered handshake and pass outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_chk_ready    <= 1'b0;
         r_report_valid <= 1'b0;
         r_pass         <= 1'b0;
      end else if (start) begin
         r_state        <= ST_RUN;
         r_chk_ready    <= 1'b1;
         r_report_valid <= 1'b0;
         r_pass         <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_chk_ready <= 1'b0;
            end
            ST_RUN: begin
               if (w_accept && chk_last) begin
                  r_state     <= ST_FLUSH;
                  r_chk_ready <= 1'b0;
               end
            end
            ST_FLUSH: begin
               r_state        <= ST_REPORT;
               r_report_valid <= 1'b1;
               r_pass         <= (w_err_next == CNT_ZERO);
            end
            ST_REPORT: begin
               if (report_ready) begin
                  r_state        <= ST_IDLE;
                  r_report_valid <= 1'b0;
                  r_pass         <= 1'b0;
               end
            end
            default: begin
               r_state        <= ST_IDLE;
               r_chk_ready    <= 1'b0;
               r_report_valid <= 1'b0;
               r_pass         <= 1'b0;
            end
         endcase
      end
   end

   // Single compare stage between acceptance and the counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p_valid <= 1'b0;
         r_p_mis   <= 1'b0;
         r_p_exp   <= VEC_ZERO;
         r_p_act   <= VEC_ZERO;
      end else if (start) begin
         r_p_valid <= 1'b0;
         r_p_mis   <= 1'b0;
         r_p_exp   <= VEC_ZERO;
         r_p_act   <= VEC_ZERO;
      end else begin
         r_p_valid <= w_accept;
         r_p_mis   <= w_mis;
         r_p_exp   <= w_exp_n;
         r_p_act   <= w_act_n;
      end
   end

   // Counters and first-error capture; the index is the pre-increment vec count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec_count <= CNT_ZERO;
         r_err_count <= CNT_ZERO;
         r_first_idx <= CNT_ZERO;
         r_first_exp <= VEC_ZERO;
         r_first_act <= VEC_ZERO;
      end else if (start) begin
         r_vec_count <= CNT_ZERO;
         r_err_count <= CNT_ZERO;
         r_first_idx <= CNT_ZERO;
         r_first_exp <= VEC_ZERO;
         r_first_act <= VEC_ZERO;
      end else begin
         r_vec_count <= w_vec_next;
         r_err_count <= w_err_next;
         if (w_p_err && (r_err_count == CNT_ZERO)) begin
            r_first_idx <= r_vec_count;
            r_first_exp <= r_p_exp;
            r_first_act <= r_p_act;
         end
      end
   end

   assign chk_ready     = r_chk_ready;
   assign report_valid  = r_report_valid;
   assign pass          = r_pass;
   assign vec_count     = r_vec_count;
   assign err_count     = r_err_count;
   assign first_err_idx = r_first_idx;
   assign first_err_exp = r_first_exp;
   assign first_err_act = r_first_act;

endmodule

// File: tb/tb_cond_check_collector.sv
// Directed bench: one SIZE=1 collector and one SIZE=2/CNT_W=3 collector
// share the control inputs; each scenario checks the instance it targets.
module tb_cond_check_collector;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        chk_valid;
   logic        chk_last;
   logic        report_ready;
   logic [3:0]  exp_v;
   logic [3:0]  act_v;

   logic        rdy_a, rv_a, pass_a;
   logic [15:0] vec_a, err_a, idx_a;
   logic [1:0]  fexp_a, fact_a;

   logic        rdy_b, rv_b, pass_b;
   logic [2:0]  vec_b, err_b, idx_b;
   logic [3:0]  fexp_b, fact_b;

   int n_checks = 0;
   int n_fail   = 0;

   cond_check_collector #(.SIZE(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .chk_valid(chk_valid),
      .chk_ready(rdy_a), .chk_last(chk_last), .exp_val(exp_v[1:0]),
      .act_val(act_v[1:0]), .report_valid(rv_a), .report_ready(report_ready),
      .pass(pass_a), .vec_count(vec_a), .err_count(err_a),
      .first_err_idx(idx_a), .first_err_exp(fexp_a), .first_err_act(fact_a)
   );

   cond_check_collector #(.SIZE(2), .CNT_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .chk_valid(chk_valid),
      .chk_ready(rdy_b), .chk_last(chk_last), .exp_val(exp_v),
      .act_val(act_v), .report_valid(rv_b), .report_ready(report_ready),
      .pass(pass_b), .vec_count(vec_b), .err_count(err_b),
      .first_err_idx(idx_b), .first_err_exp(fexp_b), .first_err_act(fact_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] e, input logic [3:0] a, input logic last);
      chk_valid = 1'b1;
      exp_v     = e;
      act_v     = a;
      chk_last  = last;
      step();
      chk_valid = 1'b0;
      chk_last  = 1'b0;
      exp_v     = 4'h0;
      act_v     = 4'h0;
   endtask

   task automatic wait_report(input string tag);
      int n;
      n = 0;
      while (!rv_a && n < 20) begin
         step();
         n++;
      end
      check_eq(tag, {31'd0, rv_a}, 32'd1);
   endtask

   task automatic release_report();
      report_ready = 1'b1;
      step();
      report_ready = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b1;
      start        = 1'b0;
      chk_valid    = 1'b0;
      chk_last     = 1'b0;
      report_ready = 1'b0;
      exp_v        = 4'h0;
      act_v        = 4'h0;
      #3 rst_n = 1'b0;
      step();
      step();
      check_eq("rst_ready", {31'd0, rdy_a}, 32'd0);
      check_eq("rst_rv",    {31'd0, rv_a},  32'd0);
      check_eq("rst_pass",  {31'd0, pass_a}, 32'd0);
      check_eq("rst_vec",   {16'd0, vec_a}, 32'd0);
      check_eq("rst_err",   {16'd0, err_a}, 32'd0);
      rst_n = 1'b1;

      // IDLE ignores everything but start
      chk_valid = 1'b1;
      chk_last  = 1'b1;
      step();
      step();
      step();
      chk_valid = 1'b0;
      chk_last  = 1'b0;
      check_eq("idle_ready", {31'd0, rdy_a}, 32'd0);
      check_eq("idle_vec",   {16'd0, vec_a}, 32'd0);
      check_eq("idle_rv",    {31'd0, rv_a},  32'd0);

      // SIZE=1 all-matching session, including Z vs X
      pulse_start();
      check_eq("run_ready", {31'd0, rdy_a}, 32'd1);
      send(4'b0000, 4'b0000, 1'b0);
      send(4'b0001, 4'b0001, 1'b0);
      send(4'b0010, 4'b0010, 1'b0);
      send(4'b0011, 4'b0010, 1'b1);
      check_eq("flush_ready", {31'd0, rdy_a}, 32'd0);
      check_eq("flush_rv",    {31'd0, rv_a},  32'd0);
      wait_report("s1_report");
      check_eq("s1_vec",  {16'd0, vec_a}, 32'd4);
      check_eq("s1_err",  {16'd0, err_a}, 32'd0);
      check_eq("s1_pass", {31'd0, pass_a}, 32'd1);
      check_eq("s1_idx",  {16'd0, idx_a}, 32'd0);
      check_eq("s1_fexp", {30'd0, fexp_a}, 32'd0);
      release_report();
      check_eq("s1_rv_off", {31'd0, rv_a}, 32'd0);

      // SIZE=2 session with two mismatches, then a held report
      pulse_start();
      send(4'b0001, 4'b0001, 1'b0);
      send(4'b0110, 4'b0100, 1'b0);
      send(4'b1111, 4'b1010, 1'b0);
      send(4'b0000, 4'b0101, 1'b1);
      wait_report("s2_report");
      for (int c = 0; c < 5; c++) begin
         check_eq("s2_hold_rv",   {31'd0, rv_b},   32'd1);
         check_eq("s2_hold_vec",  {29'd0, vec_b},  32'd4);
         check_eq("s2_hold_err",  {29'd0, err_b},  32'd2);
         check_eq("s2_hold_idx",  {29'd0, idx_b},  32'd1);
         check_eq("s2_hold_fexp", {28'd0, fexp_b}, 32'b0110);
         check_eq("s2_hold_fact", {28'd0, fact_b}, 32'b0100);
         check_eq("s2_hold_pass", {31'd0, pass_b}, 32'd0);
         step();
      end
      release_report();
      check_eq("s2_rv_off",    {31'd0, rv_b},  32'd0);
      check_eq("s2_ready_off", {31'd0, rdy_b}, 32'd0);

      // CNT_W=3 saturation with nine mismatching pairs
      pulse_start();
      for (int k = 0; k < 9; k++) begin
         send(4'b0000, 4'b0001, (k == 8));
      end
      wait_report("s3_report");
      check_eq("s3_vec",  {29'd0, vec_b},  32'd7);
      check_eq("s3_err",  {29'd0, err_b},  32'd7);
      check_eq("s3_idx",  {29'd0, idx_b},  32'd0);
      check_eq("s3_fact", {28'd0, fact_b}, 32'b0001);
      check_eq("s3_pass", {31'd0, pass_b}, 32'd0);
      release_report();

      // abort mid-session; the pair presented with start is dropped
      pulse_start();
      send(4'b0000, 4'b0000, 1'b0);
      send(4'b0000, 4'b0001, 1'b0);
      send(4'b0001, 4'b0001, 1'b0);
      check_eq("ab_pipe_vec", {16'd0, vec_a},  32'd2);
      check_eq("ab_pre_idx",  {16'd0, idx_a},  32'd1);
      check_eq("ab_pre_fact", {30'd0, fact_a}, 32'b01);
      start     = 1'b1;
      chk_valid = 1'b1;
      exp_v     = 4'b0000;
      act_v     = 4'b0001;
      step();
      start     = 1'b0;
      chk_valid = 1'b0;
      act_v     = 4'b0000;
      check_eq("ab_vec",   {16'd0, vec_a},  32'd0);
      check_eq("ab_err",   {16'd0, err_a},  32'd0);
      check_eq("ab_idx",   {16'd0, idx_a},  32'd0);
      check_eq("ab_fact",  {30'd0, fact_a}, 32'd0);
      check_eq("ab_ready", {31'd0, rdy_a},  32'd1);
      send(4'b0011, 4'b0000, 1'b0);
      send(4'b0001, 4'b0001, 1'b1);
      wait_report("ab_report");
      check_eq("ab2_vec",  {16'd0, vec_a},  32'd2);
      check_eq("ab2_err",  {16'd0, err_a},  32'd1);
      check_eq("ab2_idx",  {16'd0, idx_a},  32'd0);
      check_eq("ab2_fexp", {30'd0, fexp_a}, 32'b10);
      check_eq("ab2_fact", {30'd0, fact_a}, 32'b00);
      release_report();

      // asynchronous reset in RUN with two pairs accepted
      pulse_start();
      send(4'b0000, 4'b0001, 1'b0);
      send(4'b0001, 4'b0001, 1'b0);
      step();
      check_eq("ar_pre_vec", {16'd0, vec_a}, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check_eq("ar_ready", {31'd0, rdy_a},  32'd0);
      check_eq("ar_vec",   {16'd0, vec_a},  32'd0);
      check_eq("ar_err",   {16'd0, err_a},  32'd0);
      check_eq("ar_idx",   {16'd0, idx_a},  32'd0);
      check_eq("ar_fexp",  {30'd0, fexp_a}, 32'd0);
      step();
      rst_n     = 1'b1;
      chk_valid = 1'b1;
      chk_last  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         check_eq("ar_no_rv", {31'd0, rv_a}, 32'd0);
      end
      chk_valid = 1'b0;
      chk_last  = 1'b0;
      check_eq("ar_post_vec", {16'd0, vec_a}, 32'd0);
      pulse_start();
      send(4'b0001, 4'b0001, 1'b1);
      wait_report("ar_report");
      check_eq("ar2_vec",  {16'd0, vec_a},  32'd1);
      check_eq("ar2_pass", {31'd0, pass_a}, 32'd1);
      release_report();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cond_check_collector.md
COND_CHECK_COLLECTOR -- requirements
Module: cond_check_collector

Interface
REQ-001 Parameter: SIZE, default 1, data width in four-state bits of each compared vector.
REQ-002 Parameter: CNT_W, default 16, width of vector/error counters and error index.
REQ-003 Encoding: each four-state bit is 2 binary bits; 00=0, 01=1, 10=X, 11=Z; vectors are SIZE such pairs, bit i at [2i+1:2i].
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; opens a check session, clears results.
REQ-007 chk_valid  input  1  check strobe; a vector pair is offered.
REQ-008 chk_ready  output  1  collector accepts a pair this cycle.
REQ-009 chk_last  input  1  qualifies the accepted pair as the final one of the session.
REQ-010 exp_val  input  2*SIZE  expected (spec-model) output, encoded.
REQ-011 act_val  input  2*SIZE  actual (implementation) output, encoded.
REQ-012 report_valid  output  1  session summary is available.
REQ-013 report_ready  input  1  consumer takes the summary.
REQ-014 pass  output  1  session had zero mismatches; valid while report_valid.
REQ-015 vec_count  output  CNT_W  pairs accepted this session.
REQ-016 err_count  output  CNT_W  mismatching pairs this session.
REQ-017 first_err_idx  output  CNT_W  0-based index of the first mismatching pair.
REQ-018 first_err_exp / first_err_act  output  2*SIZE each  normalized values of the first mismatching pair.

Function
REQ-019 FSM states IDLE, RUN, FLUSH, REPORT; reset state IDLE.
REQ-020 IDLE: start -> RUN; all other inputs ignored.
REQ-021 RUN: chk_ready=1; a pair is accepted on any cycle with chk_valid && chk_ready.
REQ-022 RUN: an accepted pair with chk_last=1 -> FLUSH; chk_ready is 0 from the following cycle.
REQ-023 FLUSH: lasts exactly one cycle, retires the compare pipeline -> REPORT.
REQ-024 REPORT: report_valid=1 and outputs held stable until report_ready=1; that cycle -> IDLE.
REQ-025 Normalization: every Z (11) in both exp_val and act_val is converted to X (10) before comparing.
REQ-026 Mismatch: the normalized exp and act differ in any encoded bit; X matches only X.
REQ-027 Pipeline: one register stage; the compare result of a pair accepted in cycle N updates the counters in cycle N+1.
REQ-028 vec_count increments once per accepted pair; err_count increments once per mismatching pair (not per bit).
REQ-029 Counters saturate at 2^CNT_W-1; no wrap-around.
REQ-030 First error: first_err_idx/exp/act are captured only at the first mismatch of a session and held thereafter; they read 0 when err_count=0.
REQ-031 pass = (err_count==0), evaluated after FLUSH.
REQ-032 start in RUN, FLUSH or REPORT aborts the session: all results are cleared and the state is RUN on the next cycle; a pair presented in the same cycle as start is not accepted.
REQ-033 chk_last with chk_valid=0 has no effect.

Reset
REQ-034 While rst_n=0: state IDLE; chk_ready, report_valid, pass, all counters, first_err_* and the pipeline valid bit are 0.
REQ-035 Reset asserted mid-session discards the session without issuing a report; the first post-reset action requires start.

Structure
REQ-036 Shared package cond_check_pkg holds the FSM state enum and the four-state encoding constants (V0, V1, VX, VZ).
REQ-037 One sub-module, cond_z_to_x_norm (SIZE-parameterized, combinational), performs the Z->X normalization; it is instantiated twice.

Verification
REQ-038 SIZE=1: start, pairs (0,0),(1,1),(X,X),(Z,X) last -> report: vec_count=4, err_count=0, pass=1.
REQ-039 SIZE=2: pairs (01,01),(1X,10),(ZZ,XX),(00,11) last -> err_count=2, first_err_idx=1, first_err_exp=encoded 1X, first_err_act=encoded 10, pass=0.
REQ-040 CNT_W=3: 9 mismatching pairs -> vec_count=7, err_count=7 (saturated).
REQ-041 report_ready held 0 for 5 cycles in REPORT -> outputs stable and report_valid=1 throughout; report_ready=1 -> IDLE on the next cycle.
REQ-042 start pulsed after 3 pairs, mismatch at index 1 -> counters and first_err_* are 0 the next cycle; new pairs are indexed from 0.
REQ-043 rst_n dropped while in RUN with 2 pairs accepted -> all outputs 0 asynchronously; no report_valid after release until start and chk_last.
